// File: rtl/riscv_defs.sv
// Shared types for the front end of the dual-issue pipeline.
// Fetch pairs and in-flight request tags live here.
package riscv_defs;

    typedef struct packed {
        logic [31:0] pc;
        logic        i0_valid;
        logic [31:0] i0_inst;
        logic [31:0] i1_inst;
    } fetch_pair_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        dead;
    } fetch_tag_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of any payload type.
// Flush clears contents; kill marks every stored entry as killed.
module fetch_fifo #(
    parameter int  DEPTH   = 2,
    parameter type T       = logic,
    parameter T    RST_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   kill,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       pop_data,
    output logic                   pop_killed,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T                 mem [DEPTH];
    logic [DEPTH-1:0] killed;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RST_VAL;
            end
            killed <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
            end
            // a fresh entry is live unless it arrives with a kill
            if (kill) begin
                killed <= '1;
            end else if (push) begin
                killed[wr_ptr] <= 1'b0;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    assign pop_data   = mem[rd_ptr];
    assign pop_killed = killed[rd_ptr];
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-pair fetch with credit flow control and redirect flush.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module fetch_unit
    import riscv_defs::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          BUF_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        take_jmp,
    input  logic [31:0] jmp_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [63:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic        out_i0_valid,
    output logic [31:0] out_i0_inst,
    output logic [31:0] out_i1_inst
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    localparam fetch_pair_t PAIR_RST = '{
        pc:       RESET_ADDR,
        i0_valid: 1'b0,
        i0_inst:  32'h0,
        i1_inst:  32'h0
    };

    logic [31:0]   fetch_pc;
    logic [CW-1:0] credits;

    logic          gnt;
    logic          dead;
    logic          resp_live;
    logic          byp;
    logic          out_fire;

    fetch_tag_t    tag_push;
    fetch_tag_t    tag_head;
    logic          tag_killed;
    logic          tag_full;
    logic          tag_empty;
    logic [CW-1:0] tag_count;

    fetch_pair_t   resp_pair;
    fetch_pair_t   pair_head;
    fetch_pair_t   sel;
    logic          pair_push;
    logic          pair_pop;
    logic          pair_full;
    logic          pair_empty;
    logic [CW-1:0] pair_count;
    logic          unused_pair_kill;
    logic          unused_jmp_bits;

    assign unused_jmp_bits = ^jmp_addr[1:0];

    // credits are registered so out_ready never reaches imem_req
    assign imem_req  = !rst && (credits < CW'(BUF_DEPTH)) && !take_jmp;
    assign imem_addr = {fetch_pc[31:3], 3'b000};
    assign gnt       = imem_req && imem_gnt;

    assign tag_push  = '{pc: fetch_pc, dead: 1'b0};
    assign dead      = tag_head.dead || tag_killed;
    assign resp_live = imem_rvalid && !dead;

    assign resp_pair = '{
        pc:       tag_head.pc,
        i0_valid: !tag_head.pc[2],
        i0_inst:  imem_rdata[31:0],
        i1_inst:  imem_rdata[63:32]
    };

`ifdef FETCH_BYPASS_EN
    assign byp = pair_empty && resp_live;
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        out_valid = !pair_empty;
        sel       = pair_head;
        if (byp) begin
            out_valid = 1'b1;
            sel       = resp_pair;
        end
    end

    assign out_pc       = sel.pc;
    assign out_i0_valid = sel.i0_valid;
    assign out_i0_inst  = sel.i0_inst;
    assign out_i1_inst  = sel.i1_inst;

    assign out_fire  = out_valid && out_ready && !take_jmp;
    assign pair_push = resp_live && !take_jmp && !(byp && out_ready);
    assign pair_pop  = out_fire && !pair_empty;

    fetch_fifo #(
        .DEPTH   (BUF_DEPTH),
        .T       (fetch_tag_t)
    ) u_tag_q (
        .clk        (clk),
        .rst        (rst),
        .flush      (1'b0),
        .kill       (take_jmp),
        .push       (gnt),
        .push_data  (tag_push),
        .pop        (imem_rvalid),
        .pop_data   (tag_head),
        .pop_killed (tag_killed),
        .full       (tag_full),
        .empty      (tag_empty),
        .count      (tag_count)
    );

    fetch_fifo #(
        .DEPTH   (BUF_DEPTH),
        .T       (fetch_pair_t),
        .RST_VAL (PAIR_RST)
    ) u_pair_q (
        .clk        (clk),
        .rst        (rst),
        .flush      (take_jmp),
        .kill       (1'b0),
        .push       (pair_push),
        .push_data  (resp_pair),
        .pop        (pair_pop),
        .pop_data   (pair_head),
        .pop_killed (unused_pair_kill),
        .full       (pair_full),
        .empty      (pair_empty),
        .count      (pair_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_ADDR;
            credits  <= '0;
        end else if (take_jmp) begin
            fetch_pc <= {jmp_addr[31:2], 2'b00};
            // only dead in-flight requests still hold credits
            credits  <= tag_count - CW'(imem_rvalid);
        end else begin
            if (gnt) begin
                fetch_pc <= {fetch_pc[31:3] + 29'd1, 3'b000};
            end
            credits <= credits + CW'(gnt)
                     - CW'(imem_rvalid && dead)
                     - CW'(out_fire);
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> !tag_empty);

    assert property (@(posedge clk) disable iff (rst)
        gnt |-> !tag_full);

    assert property (@(posedge clk) disable iff (rst)
        pair_push |-> !pair_full);

    assert property (@(posedge clk) disable iff (rst)
        {1'b0, credits} == {1'b0, tag_count} + {1'b0, pair_count});

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with adjustable latency.
// Memory word at address a holds ~a.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic        i0v;
        logic [31:0] i0;
        logic [31:0] i1;
    } pair_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

`ifdef FETCH_BYPASS_EN
    localparam int FIRST_VALID_CYC = 2;
`else
    localparam int FIRST_VALID_CYC = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        take_jmp = 1'b0;
    logic [31:0] jmp_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [63:0] imem_rdata = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic        out_i0_valid;
    logic [31:0] out_i0_inst;
    logic [31:0] out_i1_inst;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;

    pair_t       got[$];
    logic [31:0] reqs[$];
    mreq_t       mq[$];

    fetch_unit #(
        .RESET_ADDR (32'h0000_0100),
        .BUF_DEPTH  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .take_jmp     (take_jmp),
        .jmp_addr     (jmp_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_i0_valid (out_i0_valid),
        .out_i0_inst  (out_i0_inst),
        .out_i1_inst  (out_i1_inst)
    );

    always #5 clk = ~clk;

    assign imem_gnt = imem_req;

    always @(posedge clk) cyc <= cyc + 1;

    // in-order memory: grant at cycle c answers at c+lat
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
            end else begin
                if (imem_rvalid && mq.size() > 0) void'(mq.pop_front());
                if (imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + lat});
            end
            @(posedge clk);
            #1;
            if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = {~(mq[0].addr + 32'd4), ~mq[0].addr};
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 64'h0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req && imem_gnt) reqs.push_back(imem_addr);
            if (out_valid && out_ready && !take_jmp)
                got.push_back('{out_pc, out_i0_valid, out_i0_inst, out_i1_inst});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_got(input int n, input int budget);
        for (int i = 0; i < budget && got.size() < n; i++) tick(1);
    endtask

    task automatic redirect(input logic [31:0] a);
        take_jmp = 1'b1;
        jmp_addr = a;
        tick(1);
        take_jmp = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++; $display("FAIL reset_req: got %b want 0", imem_req);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_pc !== 32'h100) begin
            failures++; $display("FAIL reset_pc: got %h want 00000100", out_pc);
        end
        checks++;
        if (out_i0_valid !== 1'b0) begin
            failures++; $display("FAIL reset_i0v: got %b want 0", out_i0_valid);
        end
        checks++;
        if (out_i0_inst !== 32'h0 || out_i1_inst !== 32'h0) begin
            failures++;
            $display("FAIL reset_inst: got %h/%h want 0/0", out_i0_inst, out_i1_inst);
        end
    endtask

    task automatic test_first_valid;
        int k;
        tick(1);
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL first_req: got req=%b addr=%h want 1/00000100", imem_req, imem_addr);
        end
        k = 1;
        while (!out_valid && k < 10) begin
            tick(1);
            #1;
            k++;
        end
        checks++;
        if (k != FIRST_VALID_CYC) begin
            failures++;
            $display("FAIL first_valid_cycle: got %0d want %0d", k, FIRST_VALID_CYC);
        end
    endtask

    task automatic test_sequential;
        logic [31:0] pc;
        wait_got(4, 40);
        checks++;
        if (got.size() < 4 || reqs.size() < 4) begin
            failures++;
            $display("FAIL seq_count: got %0d pairs %0d reqs want 4", got.size(), reqs.size());
        end
        for (int i = 0; i < 4 && i < got.size() && i < reqs.size(); i++) begin
            pc = 32'h100 + 32'(8 * i);
            checks++;
            if (reqs[i] !== pc) begin
                failures++; $display("FAIL seq_req%0d: got %h want %h", i, reqs[i], pc);
            end
            checks++;
            if (got[i].pc !== pc || got[i].i0v !== 1'b1) begin
                failures++;
                $display("FAIL seq_pc%0d: got %h/%b want %h/1", i, got[i].pc, got[i].i0v, pc);
            end
            checks++;
            if (got[i].i0 !== ~pc || got[i].i1 !== ~(pc + 32'd4)) begin
                failures++;
                $display("FAIL seq_inst%0d: got %h/%h want %h/%h",
                         i, got[i].i0, got[i].i1, ~pc, ~(pc + 32'd4));
            end
        end
    endtask

    task automatic test_redirect;
        got.delete();
        reqs.delete();
        take_jmp = 1'b1;
        jmp_addr = 32'h205;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++; $display("FAIL redir_req_low: got %b want 0", imem_req);
        end
        tick(1);
        take_jmp = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++;
            $display("FAIL redir_target_req: got req=%b addr=%h want 1/00000200", imem_req, imem_addr);
        end
        wait_got(2, 40);
        checks++;
        if (got.size() < 2) begin
            failures++; $display("FAIL redir_count: got %0d want 2", got.size());
        end else begin
            checks++;
            if (got[0].pc !== 32'h204 || got[0].i0v !== 1'b0) begin
                failures++;
                $display("FAIL redir_first: got %h/%b want 00000204/0", got[0].pc, got[0].i0v);
            end
            checks++;
            if (got[0].i1 !== 32'hFFFF_FDFB) begin
                failures++; $display("FAIL redir_i1: got %h want fffffdfb", got[0].i1);
            end
            checks++;
            if (got[1].pc !== 32'h208 || got[1].i0v !== 1'b1) begin
                failures++;
                $display("FAIL redir_second: got %h/%b want 00000208/1", got[1].pc, got[1].i0v);
            end
        end
    endtask

    task automatic test_redirect_inflight;
        lat = 3;
        redirect(32'h400);
        tick(2);
        got.delete();
        reqs.delete();
        redirect(32'h500);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++; $display("FAIL inflight_hold: got %b want 0", imem_req);
        end
        tick(1);
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h500) begin
            failures++;
            $display("FAIL inflight_resume: got req=%b addr=%h want 1/00000500", imem_req, imem_addr);
        end
        wait_got(2, 40);
        checks++;
        if (got.size() < 2 || reqs.size() < 1) begin
            failures++; $display("FAIL inflight_count: got %0d want 2", got.size());
        end else begin
            checks++;
            if (reqs[0] !== 32'h500) begin
                failures++; $display("FAIL inflight_req0: got %h want 00000500", reqs[0]);
            end
            checks++;
            if (got[0].pc !== 32'h500 || got[0].i0v !== 1'b1) begin
                failures++;
                $display("FAIL inflight_first: got %h/%b want 00000500/1", got[0].pc, got[0].i0v);
            end
            checks++;
            if (got[1].pc !== 32'h508) begin
                failures++; $display("FAIL inflight_second: got %h want 00000508", got[1].pc);
            end
        end
    endtask

    task automatic test_backpressure;
        lat = 1;
        out_ready = 1'b0;
        got.delete();
        reqs.delete();
        redirect(32'h0);
        tick(9);
        #1;
        checks++;
        if (reqs.size() != 2) begin
            failures++; $display("FAIL bp_req_count: got %0d want 2", reqs.size());
        end
        checks++;
        if (imem_req !== 1'b0) begin
            failures++; $display("FAIL bp_req_low: got %b want 0", imem_req);
        end
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_i0_inst !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL bp_head: got v=%b pc=%h i0=%h want 1/00000000/ffffffff",
                     out_valid, out_pc, out_i0_inst);
        end
        checks++;
        if (got.size() != 0) begin
            failures++; $display("FAIL bp_no_accept: got %0d want 0", got.size());
        end
        tick(1);
        out_ready = 1'b1;
        wait_got(3, 40);
        checks++;
        if (got.size() < 3 || reqs.size() < 3) begin
            failures++; $display("FAIL bp_drain_count: got %0d want 3", got.size());
        end else begin
            checks++;
            if (got[0].pc !== 32'h0 || got[1].pc !== 32'h8 || got[2].pc !== 32'h10) begin
                failures++;
                $display("FAIL bp_order: got %h %h %h want 0 8 10", got[0].pc, got[1].pc, got[2].pc);
            end
            checks++;
            if (reqs[0] !== 32'h0 || reqs[1] !== 32'h8 || reqs[2] !== 32'h10) begin
                failures++;
                $display("FAIL bp_reqs: got %h %h %h want 0 8 10", reqs[0], reqs[1], reqs[2]);
            end
        end
    endtask

    task automatic test_wrap;
        got.delete();
        reqs.delete();
        redirect(32'hFFFF_FFF8);
        wait_got(2, 40);
        checks++;
        if (got.size() < 2 || reqs.size() < 2) begin
            failures++; $display("FAIL wrap_count: got %0d want 2", got.size());
        end else begin
            checks++;
            if (reqs[0] !== 32'hFFFF_FFF8 || reqs[1] !== 32'h0) begin
                failures++;
                $display("FAIL wrap_req: got %h %h want fffffff8 00000000", reqs[0], reqs[1]);
            end
            checks++;
            if (got[0].pc !== 32'hFFFF_FFF8 || got[1].pc !== 32'h0) begin
                failures++;
                $display("FAIL wrap_pc: got %h %h want fffffff8 00000000", got[0].pc, got[1].pc);
            end
            checks++;
            if (got[1].i0 !== 32'hFFFF_FFFF || got[0].i1 !== 32'h0000_0003) begin
                failures++;
                $display("FAIL wrap_inst: got %h %h want ffffffff 00000003", got[1].i0, got[0].i1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_valid();
        test_sequential();
        test_redirect();
        test_redirect_inflight();
        test_backpressure();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
